// File: rtl/nibble_serial_sub_ctrl.sv
// Wide X - Y - Bin computed one nibble per clock through a single shared
// 4-bit borrow-lookahead subtractor, with a start/done handshake.

module Lab2_borrow_lookahead_sub (
  output logic [3:0] Diff,
  output logic       Bout,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Bin
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] b;

  // A borrow is generated when x=0,y=1 and passed through when x==y.
  assign g = ~X & Y;
  assign p = ~(X ^ Y);

  assign b[0] = Bin;
  assign b[1] = g[0] | (p[0] & Bin);
  assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Bin);
  assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Bin);
  assign Bout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Bin);

  assign Diff = X ^ Y ^ b;
endmodule

module nibble_serial_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] X,
  input  logic [4*NIBBLES-1:0] Y,
  input  logic                 Bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Diff,
  output logic                 Bout,
  output logic                 zero
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_n;
  logic           accept;
  logic           last;
  logic [W-1:0]   xq;
  logic [W-1:0]   yq;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic [CW+1:0]  base;
  logic [W-1:0]   diff_q;
  logic [W-1:0]   diff_n;
  logic           bout_q;
  logic           zero_q;
  logic [3:0]     s_diff;
  logic           s_bout;

  assign base = {cnt, 2'b00};

  Lab2_borrow_lookahead_sub u_sub (
    .Diff (s_diff),
    .Bout (s_bout),
    .X    (xq[base +: 4]),
    .Y    (yq[base +: 4]),
    .Bin  (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    diff_n  = diff_q;
    diff_n[base +: 4] = s_diff;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xq     <= '0;
      yq     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      xq     <= X;
      yq     <= Y;
      borrow <= Bin;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (state == RUN) begin
      diff_q <= diff_n;
      borrow <= s_bout;
      if (last) begin
        bout_q <= s_bout;
        // zero must see the nibble being written on this same edge
        zero_q <= (diff_n == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign zero = zero_q;
endmodule

// File: doc/nibble_serial_sub_ctrl.md
Name: nibble_serial_sub_ctrl

Overview:
Sequencer that performs a wide (4*NIBBLES-bit) subtraction X - Y - Bin by time-sharing one instance of the team's 4-bit borrow-lookahead subtractor Lab2_borrow_lookahead_sub(Diff, Bout, X, Y, Bin). It processes one nibble per clock, LSB nibble first, and chains the borrow through a register. It sits between a requester using a start/done handshake and the shared 4-bit subtractor datapath. It also reports borrow-out and zero flags.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal values 2..8).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse/level; sampled only when ready.
X  input  W  minuend; sampled on the accepting edge.
Y  input  W  subtrahend; sampled on the accepting edge.
Bin  input  1  initial borrow-in; sampled on the accepting edge.
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse; results valid from this cycle on.
Diff  output  W  result X - Y - Bin mod 2^W.
Bout  output  1  final borrow; 1 iff X < Y + Bin (unsigned).
zero  output  1  1 iff Diff == 0.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, Diff=0, Bout=0, zero=0. Operand registers, borrow register and nibble counter are all 0.
- Reset mid-operation aborts immediately. No partial result is retained, and the block returns to IDLE.
- States:
  - IDLE: ready. On a rising edge with start=1: latch X, Y, Bin; set cnt=0; borrow_reg=Bin; clear Diff, Bout and zero; busy=1; go to RUN.
  - RUN: each edge writes the subtractor Diff output to Diff[4*cnt+3:4*cnt] and loads the subtractor Bout into borrow_reg. The subtractor inputs are nibble cnt of latched X, nibble cnt of latched Y, and borrow_reg. On the edge where cnt == NIBBLES-1: Bout <= slice Bout, zero <= (full Diff == 0, including the final nibble), busy <= 0, done <= 1, go to DONE. Otherwise cnt increments.
  - DONE: lasts exactly one cycle with done=1, then done returns to 0. In this cycle start=1 is accepted exactly as in IDLE, giving back-to-back operation; otherwise the next state is IDLE.
- Latency: if start is accepted at edge k, the nibble writes occur at edges k+1..k+NIBBLES. done is high during the cycle following edge k+NIBBLES, and busy is high for exactly NIBBLES cycles.
- start while busy (RUN) is ignored. Latched operands do not change, and no request is queued.
- Diff, Bout and zero hold their values after done until the next accepted start, which clears them.
- Holding start at 1 continuously restarts on every DONE cycle. Each operation samples the current X, Y and Bin.
- The subtractor instance is purely combinational, with no registers inside the slice. The counter is sized ceil(log2(NIBBLES)) bits, minimum 1.
- Arithmetic: Diff = (X - Y - Bin) mod 2^W, and Bout = borrow out of the MSB slice. These must equal a single-cycle W-bit reference model.

Test Plan:
1. Basic subtract: X=16'h1234, Y=16'h0234, Bin=0, start pulse at edge k -> busy high for 4 cycles; done pulse after edge k+4; Diff=16'h1000, Bout=0, zero=0.
2. Full borrow ripple: X=16'h0000, Y=16'h0001, Bin=0 -> Diff=16'hFFFF, Bout=1, zero=0. Also X=16'h8000, Y=16'h7FFF, Bin=0 -> Diff=16'h0001, Bout=0.
3. Equal operands and Bin:
   - X=Y=16'hABCD, Bin=0 -> Diff=16'h0000, zero=1, Bout=0.
   - Same operands with Bin=1 -> Diff=16'hFFFF, Bout=1, zero=0.
4. Start during busy: start X=16'h00FF, Y=16'h000F. Two cycles later, pulse start with X=16'h0001, Y=16'h0001 -> ignored; result Diff=16'h00F0, done fires once.
5. Back-to-back: hold start=1 -> ops accepted in IDLE, then in each DONE cycle; done every 5 cycles; each result matches the operands sampled at its accepting edge.
6. Reset mid-run: assert rst_n=0 asynchronously after 2 RUN cycles -> busy, done, Diff, Bout and zero go to 0 without waiting for clk. After release, a new op X=16'h0010, Y=16'h0001 -> Diff=16'h000F. Repeat with NIBBLES=2: 8'h5A-8'hA5, Bin=0 -> Diff=8'hB5, Bout=1, done after 2 cycles.
